hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have one clock, clk (input, 1, rising-edge), and one reset, reset_n (input, 1), which is asynchronous and active-low.
REQ-002 The block SHALL have these decode-stage inputs: rsD, rtD (input, 5 each, source register numbers); branchD (input, 1, branch in decode); pcsrcD (input, 1, branch taken).
REQ-003 The block SHALL have these execute-stage inputs: rsE, rtE, writeregE (input, 5 each); regwriteE, memtoregE (input, 1 each).
REQ-004 The block SHALL have these memory-stage inputs: writeregM (input, 5); regwriteM, memtoregM, memwriteM (input, 1 each).
REQ-005 The block SHALL have these writeback-stage inputs: writeregW (input, 5); regwriteW (input, 1).
REQ-006 The block SHALL have these memory-handshake ports: mem_ready (input, 1, data-memory acknowledge); mem_req (output, 1, data-memory request).
REQ-007 The block SHALL have these pipeline-control outputs: stallF, stallD, flushD, flushE, stallE, stallM, stallW (output, 1 each).
REQ-008 The block SHALL have these forwarding outputs: forwardAD, forwardBD (output, 1 each); forwardAE, forwardBE (output, 2 each).
REQ-009 The block SHALL have these counter ports: clr_count (input, 1, synchronous clear); stall_count (output, 16, saturating stall-cycle count).

Function
REQ-010 forwardAE SHALL be 2'b10 if regwriteM and writeregM!=0 and writeregM==rsE; else 2'b01 if regwriteW and writeregW!=0 and writeregW==rsE; else 2'b00. forwardBE SHALL use the same rules with rtE.
REQ-011 forwardAD SHALL be 1 iff regwriteM and writeregM!=0 and writeregM==rsD; forwardBD SHALL use the same rule with rtD.
REQ-012 lwstall SHALL be memtoregE and (rtE==rsD or rtE==rtD).
REQ-013 branchstall SHALL be branchD and either (regwriteE and writeregE in {rsD,rtD}) or (memtoregM and writeregM in {rsD,rtD}).
REQ-014 Memory FSM states SHALL be IDLE, WAIT and DONE; memaccM = memtoregM or memwriteM.
REQ-015 IDLE: with memaccM=1 -> mem_req=1, mem_stall=1, next state WAIT; with memaccM=0 -> stay IDLE, mem_req=0, mem_stall=0.
REQ-016 WAIT: mem_req=1 and mem_stall=1; mem_ready sampled high at a clock edge -> DONE; otherwise stay in WAIT, with no timeout.
REQ-017 DONE: mem_req=0 and mem_stall=0 so the pipeline advances one cycle; next state IDLE unconditionally, including when a new access is already in M.
REQ-018 mem_ready SHALL be ignored in IDLE and DONE.
REQ-019 Each memory access SHALL cost a minimum of 2 stall cycles.
REQ-020 stallE, stallM and stallW SHALL equal mem_stall.
REQ-021 stallF and stallD SHALL equal lwstall or branchstall or mem_stall.
REQ-022 flushE SHALL equal (lwstall or branchstall) and not mem_stall.
REQ-023 flushD SHALL equal pcsrcD and not stallD.
REQ-024 When a hazard and mem_stall occur simultaneously, mem_stall SHALL take priority: the whole pipeline freezes, nothing is flushed, and the hazard is re-evaluated after release.
REQ-025 stall_count SHALL increment by 1 on each edge where stallF=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 clr_count=1 SHALL load 0 at the edge and SHALL take priority over the increment.
REQ-027 Except for the registered FSM state and stall_count, all outputs SHALL be combinational functions of the current inputs and FSM state, with zero-cycle latency.

Reset
REQ-028 While reset_n=0, the FSM SHALL be IDLE, stall_count SHALL be 0, and mem_req and mem_stall SHALL be forced to 0, with reset taking effect asynchronously.
REQ-029 Asserting reset while in WAIT SHALL drop mem_req immediately, without waiting for a clock edge.
REQ-030 While reset_n=0, forwarding outputs and the lwstall, branchstall and flush terms SHALL still follow REQ-010 to REQ-013 and REQ-021 to REQ-023, evaluated with mem_stall=0.
REQ-031 After reset_n rises, the first edge SHALL evaluate IDLE normally.

Verification
REQ-032 Forwarding: regwriteM=1, writeregM=5, rsE=5, regwriteW=1, writeregW=5 -> forwardAE=2'b10; then writeregM=0 with rsE=0 -> forwardAE=2'b00.
REQ-033 Load-use: memtoregE=1, rtE=7, rsD=7, no memory access in M -> stallF=stallD=flushE=1, stallE=0, stall_count +1 per cycle.
REQ-034 Memory wait: memwriteM=1 in IDLE, mem_ready low for 3 cycles then high -> mem_req high for 5 cycles (IDLE, WAIT x3, ready cycle), DONE with all stalls 0, then IDLE; stall_count +5.
REQ-035 Collision: lwstall active while in WAIT -> flushE=0 and all stalls 1; in DONE, flushE=1 and stallF=1.
REQ-036 Reset mid-WAIT: reset_n low -> mem_req=0 the same cycle, stall_count=0; after release with memaccM=1 -> IDLE asserts mem_req on the first cycle.
REQ-037 Saturation and clear: hold stallF for 65540 cycles -> stall_count=16'hFFFF; assert clr_count together with stallF -> stall_count=0 next edge.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and
// branch interlocks, a data-memory handshake FSM that freezes the pipe
// while an access is outstanding, and a saturating stall-cycle counter.

// One forwarding lane: resolves the E-stage mux select and the D-stage
// compare-bypass for a single source operand.
module hazard_fwd_lane (
  input  logic [4:0] srcE,
  input  logic [4:0] srcD,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  output logic [1:0] fwdE,
  output logic       fwdD
);
  logic hitM_E, hitW_E;
  assign hitM_E = regwriteM && (writeregM != 5'd0) && (writeregM == srcE);
  assign hitW_E = regwriteW && (writeregW != 5'd0) && (writeregW == srcE);
  // M result is newer than W, so it wins
  assign fwdE   = hitM_E ? 2'b10 : (hitW_E ? 2'b01 : 2'b00);
  assign fwdD   = regwriteM && (writeregM != 5'd0) && (writeregM == srcD);
endmodule

module hazard_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        pcsrcD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic        regwriteE,
  input  logic        memtoregE,
  input  logic [4:0]  writeregM,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteW,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  input  logic        clr_count,
  output logic [15:0] stall_count
);
  localparam int NUM_LANES = 2;  // lane 0 = rs (A), lane 1 = rt (B)

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [NUM_LANES-1:0][4:0] srcE, srcD;
  logic [NUM_LANES-1:0][1:0] fwdE;
  logic [NUM_LANES-1:0]      fwdD;

  assign srcE = {rtE, rsE};
  assign srcD = {rtD, rsD};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      hazard_fwd_lane u_lane (
        .srcE      (srcE[g]),
        .srcD      (srcD[g]),
        .writeregM (writeregM),
        .regwriteM (regwriteM),
        .writeregW (writeregW),
        .regwriteW (regwriteW),
        .fwdE      (fwdE[g]),
        .fwdD      (fwdD[g])
      );
    end
  endgenerate

  assign forwardAE = fwdE[0];
  assign forwardBE = fwdE[1];
  assign forwardAD = fwdD[0];
  assign forwardBD = fwdD[1];

  // Interlocks
  logic lwstall, branchstall, hzd;
  assign lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign branchstall = branchD &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign hzd         = lwstall || branchstall;

  // Memory handshake FSM
  logic [1:0] state, state_nx;
  logic       memaccM, req_raw, mstall_raw, mem_stall;
  assign memaccM = memtoregM || memwriteM;

  // Next-state and handshake outputs; DONE is a one-cycle release slot
  always_comb begin
    state_nx   = state;
    req_raw    = 1'b0;
    mstall_raw = 1'b0;
    case (state)
      S_IDLE: if (memaccM) begin
        req_raw    = 1'b1;
        mstall_raw = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        req_raw    = 1'b1;
        mstall_raw = 1'b1;
        if (mem_ready) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Gate with reset so the request drops the instant reset asserts,
  // even for an IDLE-state request that has no register behind it.
  assign mem_req   = req_raw && reset_n;
  assign mem_stall = mstall_raw && reset_n;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Pipeline control: a memory freeze overrides hazard flushing
  assign stallE = mem_stall;
  assign stallM = mem_stall;
  assign stallW = mem_stall;
  assign stallF = hzd || mem_stall;
  assign stallD = hzd || mem_stall;
  assign flushE = hzd && !mem_stall;
  assign flushD = pcsrcD && !stallD;

  // Saturating stall-cycle counter, clear wins over increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             stall_count <= 16'd0;
    else if (clr_count)                       stall_count <= 16'd0;
    else if (stallF && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule
